// File: rtl/fir3_pkg.sv
// Shared definitions for the time-shared 3-tap FIR scheduler.
//   - state_t     : scheduler FSM states
//   - widths      : sample (10), coefficient/accumulator (12), product (24)
//   - K*_DEF      : default coefficient values (Q1.11)
//   - sat12()     : clamps a 13-bit sum into the 12-bit signed range
package fir3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAP0,
        ST_TAP1,
        ST_TAP2,
        ST_WB
    } state_t;

    localparam int NCH_MAX = 4;
    localparam int SMP_W   = 10;
    localparam int COEF_W  = 12;
    localparam int ACC_W   = 12;
    localparam int PROD_W  = 24;

    localparam logic [COEF_W-1:0] K0_DEF = 12'hc00;  // -0.5
    localparam logic [COEF_W-1:0] K1_DEF = 12'h500;  // 0.625
    localparam logic [COEF_W-1:0] K2_DEF = 12'hc00;  // -0.5

    // A 13-bit sum overflowed the 12-bit range exactly when its two top
    // bits disagree; the top bit then tells which rail to clamp to.
    function automatic logic [ACC_W-1:0] sat12(input logic [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/fir3_mul12.sv
// Signed 12x12 -> 24 combinational multiplier shared by all channels.
// Behavioural stand-in for the vendor multiplier core (mult_gen_0); the
// synthesis tool maps the product onto a single DSP slice.
//   a : signed multiplicand (coefficient, Q1.11)
//   b : signed multiplier   (sample shifted left by 2)
//   p : signed full-precision product
module fir3_mul12
    import fir3_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    assign p = $signed(a) * $signed(b);

endmodule

// File: rtl/fir3_mult_sched.sv
// Time-shares one signed 12x12 multiplier across NCH independent 3-tap FIR
// channels: y[n] = k0*x[n] + k1*x[n-1] + k2*x[n-2].
// Ports:
//   clk, reset (async, active-low)
//   irdy/din   : per-channel sample offer; iack pulses the cycle after capture
//   ordy/dout  : per-channel fresh-result level and result
//   ovf        : per-channel sticky "sample dropped" flag
//   cfg_we/cfg_ch/cfg_tap/cfg_data : run-time coefficient writes
// Each sample takes IDLE(grant) -> TAP0 -> TAP1 -> TAP2 -> WB, i.e. five
// cycles from capture to result; channels are granted round-robin.
module fir3_mult_sched
    import fir3_pkg::*;
#(
    parameter int                NCH    = 2,
    parameter logic [COEF_W-1:0] K0_RST = K0_DEF,
    parameter logic [COEF_W-1:0] K1_RST = K1_DEF,
    parameter logic [COEF_W-1:0] K2_RST = K2_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         irdy,
    input  logic [NCH*SMP_W-1:0]   din,
    output logic [NCH-1:0]         iack,
    output logic [NCH-1:0]         ordy,
    output logic [NCH*SMP_W-1:0]   dout,
    output logic [NCH-1:0]         ovf,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_ch,
    input  logic [1:0]             cfg_tap,
    input  logic [COEF_W-1:0]      cfg_data
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // Scheduler / working copy of the channel in service
    state_t            state_reg;
    logic [CW-1:0]     cur_ch_reg;
    logic [CW-1:0]     rr_ptr_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [SMP_W-1:0]  wx0_reg, wx1_reg, wx2_reg;
    logic [COEF_W-1:0] wk0_reg, wk1_reg, wk2_reg;

    // Per-channel state
    logic [NCH-1:0]    pend_reg;
    logic [NCH-1:0]    iack_reg;
    logic [NCH-1:0]    ordy_reg;
    logic [NCH-1:0]    ovf_reg;
    logic [SMP_W-1:0]  xbuf_reg [NCH];
    logic [SMP_W-1:0]  x1_reg   [NCH];
    logic [SMP_W-1:0]  x2_reg   [NCH];
    logic [SMP_W-1:0]  dout_reg [NCH];
    logic [COEF_W-1:0] k0_reg   [NCH];
    logic [COEF_W-1:0] k1_reg   [NCH];
    logic [COEF_W-1:0] k2_reg   [NCH];

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from rr_ptr upward, first pending wins.
    // Scanning offsets downward lets the smallest offset overwrite last.
    // ------------------------------------------------------------------
    logic          gnt_valid;
    logic [CW-1:0] gnt_ch;
    logic [CW-1:0] scan_idx;
    logic          grant;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        scan_idx  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            scan_idx = CW'((int'(rr_ptr_reg) + i) % NCH);
            if (pend_reg[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_ch    = scan_idx;
            end
        end
    end

    assign grant = (state_reg == ST_IDLE) && gnt_valid;

    // ------------------------------------------------------------------
    // Shared multiplier and saturating accumulate
    // ------------------------------------------------------------------
    logic [COEF_W-1:0] mul_a;
    logic [SMP_W-1:0]  mul_x;
    logic [COEF_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  pdrop;
    logic [ACC_W:0]    acc_sum;
    logic              unused_prod_msb;

    always_comb begin
        mul_a = wk0_reg;
        mul_x = wx0_reg;
        case (state_reg)
            ST_TAP1: begin
                mul_a = wk1_reg;
                mul_x = wx1_reg;
            end
            ST_TAP2: begin
                mul_a = wk2_reg;
                mul_x = wx2_reg;
            end
            default: ;
        endcase
    end

    // Sample is left-aligned into the 12-bit operand (x4).
    assign mul_b = {mul_x, 2'b00};

    fir3_mul12 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Bit 23 is deliberately discarded: the Q-format drop keeps [22:11].
    assign pdrop           = prod[22:11];
    assign unused_prod_msb = prod[PROD_W-1];
    assign acc_sum         = {acc_reg[ACC_W-1], acc_reg} + {pdrop[ACC_W-1], pdrop};

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cur_ch_reg <= '0;
            rr_ptr_reg <= '0;
            acc_reg    <= '0;
            wx0_reg    <= '0;
            wx1_reg    <= '0;
            wx2_reg    <= '0;
            wk0_reg    <= '0;
            wk1_reg    <= '0;
            wk2_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant) begin
                        cur_ch_reg <= gnt_ch;
                        rr_ptr_reg <= (int'(gnt_ch) == NCH - 1) ? '0 : gnt_ch + 1'b1;
                        wx0_reg    <= xbuf_reg[gnt_ch];
                        wx1_reg    <= x1_reg[gnt_ch];
                        wx2_reg    <= x2_reg[gnt_ch];
                        wk0_reg    <= k0_reg[gnt_ch];
                        wk1_reg    <= k1_reg[gnt_ch];
                        wk2_reg    <= k2_reg[gnt_ch];
                        acc_reg    <= '0;
                        state_reg  <= ST_TAP0;
                    end
                end
                ST_TAP0: begin
                    acc_reg   <= sat12(acc_sum);
                    state_reg <= ST_TAP1;
                end
                ST_TAP1: begin
                    acc_reg   <= sat12(acc_sum);
                    state_reg <= ST_TAP2;
                end
                ST_TAP2: begin
                    acc_reg   <= sat12(acc_sum);
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-channel buffer, history, result and coefficient bank
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic granted;
            logic accept;
            logic wb_hit;
            logic cfg_hit;

            assign granted = grant && (int'(gnt_ch) == gi);
            // A grant at the same edge frees the buffer, so back-to-back
            // samples are not dropped.
            assign accept  = irdy[gi] && (!pend_reg[gi] || granted);
            assign wb_hit  = (state_reg == ST_WB) && (int'(cur_ch_reg) == gi);
            assign cfg_hit = cfg_we && (int'(cfg_ch) == gi);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pend_reg[gi] <= 1'b0;
                    iack_reg[gi] <= 1'b0;
                    ordy_reg[gi] <= 1'b0;
                    ovf_reg[gi]  <= 1'b0;
                    xbuf_reg[gi] <= '0;
                    x1_reg[gi]   <= '0;
                    x2_reg[gi]   <= '0;
                    dout_reg[gi] <= '0;
                    k0_reg[gi]   <= K0_RST;
                    k1_reg[gi]   <= K1_RST;
                    k2_reg[gi]   <= K2_RST;
                end else begin
                    iack_reg[gi] <= accept;

                    if (accept) begin
                        pend_reg[gi] <= 1'b1;
                        xbuf_reg[gi] <= din[gi*SMP_W +: SMP_W];
                    end else if (granted) begin
                        pend_reg[gi] <= 1'b0;
                    end

                    if (irdy[gi] && !accept) begin
                        ovf_reg[gi] <= 1'b1;
                    end

                    // A newly accepted sample makes any held result stale.
                    if (accept) begin
                        ordy_reg[gi] <= 1'b0;
                    end else if (wb_hit) begin
                        ordy_reg[gi] <= 1'b1;
                    end

                    if (wb_hit) begin
                        dout_reg[gi] <= acc_reg[ACC_W-1:2];
                        x2_reg[gi]   <= x1_reg[gi];
                        x1_reg[gi]   <= wx0_reg;
                    end

                    if (cfg_hit) begin
                        case (cfg_tap)
                            2'd0:    k0_reg[gi] <= cfg_data;
                            2'd1:    k1_reg[gi] <= cfg_data;
                            2'd2:    k2_reg[gi] <= cfg_data;
                            default: ;
                        endcase
                    end
                end
            end

            assign dout[gi*SMP_W +: SMP_W] = dout_reg[gi];
        end
    endgenerate

    assign iack = iack_reg;
    assign ordy = ordy_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_fir3_mult_sched.sv
// Directed bench for fir3_mult_sched (NCH=2, default coefficients).
// Expected values are hand-derived: with k0=k2=-0.5 and k1=0.625 a sample x
// contributes -2x, floor(2.5x), -2x to the 12-bit accumulator, and dout is
// the accumulator divided by 4.
module tb_fir3_mult_sched;

    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    irdy = '0;
    logic [NCH*10-1:0] din = '0;
    logic [NCH-1:0]    iack;
    logic [NCH-1:0]    ordy;
    logic [NCH*10-1:0] dout;
    logic [NCH-1:0]    ovf;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [1:0]        cfg_tap = '0;
    logic [11:0]       cfg_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    fir3_mult_sched #(.NCH(NCH)) dut (
        .clk      (clk),
        .reset    (reset),
        .irdy     (irdy),
        .din      (din),
        .iack     (iack),
        .ordy     (ordy),
        .dout     (dout),
        .ovf      (ovf),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_tap  (cfg_tap),
        .cfg_data (cfg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] ch, input logic [1:0] tap, input logic [11:0] data);
        cfg_we = 1'b1; cfg_ch = ch; cfg_tap = tap; cfg_data = data;
        tick();
        cfg_we = 1'b0;
        $display("cfg ch=%0d tap=%0d data=0x%03h", ch, tap, data);
    endtask

    // Single-channel sample: checks iack, the 5-cycle latency and the result.
    task automatic send1(input int ch, input logic [9:0] d, input logic [9:0] exp, input string tag);
        irdy = '0;
        irdy[ch] = 1'b1;
        din[ch*10 +: 10] = d;
        tick();
        irdy = '0;
        chk({tag, "_iack"}, 32'(iack), 32'(1 << ch));
        repeat (4) tick();
        chk({tag, "_ordy_early"}, 32'(ordy[ch]), 32'd0);
        tick();
        chk({tag, "_ordy"}, 32'(ordy[ch]), 32'd1);
        chk({tag, "_dout"}, 32'(dout[ch*10 +: 10]), 32'(exp));
        $display("txn %s ch=%0d din=0x%03h dout=0x%03h", tag, ch, d, dout[ch*10 +: 10]);
    endtask

    // Simultaneous samples on both channels; 'first' is the expected winner.
    task automatic send2(input logic [9:0] d0, input logic [9:0] d1, input int first,
                         input logic [9:0] e_first, input logic [9:0] e_second, input string tag);
        int second;
        second = 1 - first;
        irdy = 2'b11;
        din = {d1, d0};
        tick();
        irdy = '0;
        chk({tag, "_iack"}, 32'(iack), 32'd3);
        repeat (4) tick();
        chk({tag, "_ordy_early"}, 32'(ordy), 32'd0);
        tick();
        chk({tag, "_ordy_first"}, 32'(ordy), 32'(1 << first));
        chk({tag, "_dout_first"}, 32'(dout[first*10 +: 10]), 32'(e_first));
        repeat (4) tick();
        chk({tag, "_ordy2_early"}, 32'(ordy[second]), 32'd0);
        tick();
        chk({tag, "_ordy_second"}, 32'(ordy[second]), 32'd1);
        chk({tag, "_dout_second"}, 32'(dout[second*10 +: 10]), 32'(e_second));
        $display("txn %s first=ch%0d dout0=0x%03h dout1=0x%03h", tag, first, dout[9:0], dout[19:10]);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_ordy", 32'(ordy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_iack", 32'(iack), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        reset = 1'b1;
        tick();

        // ---------------- impulse on ch0 ----------------
        send1(0, 10'h100, 10'h380, "imp0");
        send1(0, 10'h000, 10'h0a0, "imp1");
        send1(0, 10'h000, 10'h380, "imp2");
        send1(0, 10'h000, 10'h000, "imp3");

        // ---------------- round robin ----------------
        // ch0 was served last, so ch1 wins the first pair.
        send2(10'h100, 10'h100, 1, 10'h380, 10'h380, "pair_a");
        // ch1 history x1=0x100 -> 2.5*256/4
        send1(1, 10'h000, 10'h0a0, "ch1_solo");
        // ch1 served last -> ch0 first; ch0 x1=0x100, ch1 x2=0x100
        send2(10'h000, 10'h000, 0, 10'h0a0, 10'h380, "pair_b");

        // ---------------- overrun ----------------
        irdy = 2'b10; din[19:10] = 10'h100;
        tick();                                   // E0: ch1 captured
        chk("ovr_iack1", 32'(iack), 32'd2);
        irdy = 2'b01; din[9:0] = 10'h100;
        tick();                                   // E1: ch1 granted, ch0 captured
        chk("ovr_iack0", 32'(iack), 32'd1);
        din[9:0] = 10'h055;
        tick();                                   // E2: dropped
        chk("ovr_iack_drop", 32'(iack), 32'd0);
        chk("ovr_flag", 32'(ovf), 32'd1);
        din[9:0] = 10'h0aa;
        tick();                                   // E3: dropped
        irdy = '0;
        chk("ovr_flag2", 32'(ovf), 32'd1);
        repeat (2) tick();                        // E5: ch1 result
        chk("ovr_ordy_ch1", 32'(ordy), 32'd2);
        chk("ovr_dout_ch1", 32'(dout[19:10]), 32'h380);
        repeat (4) tick();
        chk("ovr_ordy0_early", 32'(ordy[0]), 32'd0);
        tick();                                   // E10: ch0 result from first sample
        chk("ovr_ordy_ch0", 32'(ordy[0]), 32'd1);
        chk("ovr_dout_ch0", 32'(dout[9:0]), 32'h300);
        chk("ovr_sticky", 32'(ovf), 32'd1);
        $display("txn overrun dout0=0x%03h dout1=0x%03h ovf=%b", dout[9:0], dout[19:10], ovf);

        // ---------------- saturation on ch1 ----------------
        cfg_wr(2'd1, 2'd0, 12'h7ff);
        cfg_wr(2'd1, 2'd1, 12'h7ff);
        cfg_wr(2'd1, 2'd2, 12'h7ff);
        send1(1, 10'h1ff, 10'h1ff, "sat0");
        send1(1, 10'h1ff, 10'h1ff, "sat1");
        send1(1, 10'h1ff, 10'h1ff, "sat2");

        // ---------------- coefficient write during TAP1 ----------------
        // ch0 history x1=0x100, x2=0: old k1 gives (-512+640)/4 = 0x020
        irdy = 2'b01; din[9:0] = 10'h100;
        tick();                                   // E0
        irdy = '0;
        repeat (2) tick();                        // E1 grant, E2 -> TAP1
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_tap = 2'd1; cfg_data = 12'h7ff;
        tick();                                   // E3: bank write
        cfg_we = 1'b0;
        repeat (2) tick();                        // E5
        chk("cfgmid_ordy", 32'(ordy[0]), 32'd1);
        chk("cfgmid_dout", 32'(dout[9:0]), 32'h020);
        $display("txn cfgmid ch=0 dout=0x%03h", dout[9:0]);
        // x1=x2=0x100, new k1: (1023-512)/4 = 0x07f
        send1(0, 10'h000, 10'h07f, "cfgnext");

        // ---------------- ignored writes ----------------
        cfg_wr(2'd3, 2'd0, 12'h800);
        cfg_wr(2'd0, 2'd3, 12'h000);
        send1(1, 10'h1ff, 10'h1ff, "ign_ch1");
        // ch0 x1=0, x2=0x100: (-512-512)/4 = 0x300
        send1(0, 10'h100, 10'h300, "ign_ch0");

        // ---------------- reset during TAP2 ----------------
        irdy = 2'b01; din[9:0] = 10'h100;
        tick();                                   // E0
        irdy = '0;
        repeat (3) tick();                        // E3 -> TAP2
        reset = 1'b0;
        #1;
        chk("mrst_ordy", 32'(ordy), 32'd0);
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_ovf",  32'(ovf),  32'd0);
        chk("mrst_iack", 32'(iack), 32'd0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("mrst_no_ordy", 32'(ordy), 32'd0);
        chk("mrst_no_dout", 32'(dout), 32'd0);
        $display("txn midreset ordy=%b dout=0x%05h", ordy, dout);

        send1(0, 10'h100, 10'h380, "rimp0");
        send1(0, 10'h000, 10'h0a0, "rimp1");
        send1(0, 10'h000, 10'h380, "rimp2");
        send1(0, 10'h000, 10'h000, "rimp3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
